exu_branch_ctrl: RTL and testbench

EXU_BRANCH_CTRL -- requirements
Module: exu_branch_ctrl

---
 rtl/exu_branch_ctrl_pkg.sv | 25 ++
 rtl/branch_cond_eval.sv | 27 ++
 rtl/exu_branch_ctrl.sv | 158 +++++++++++++++
 tb/tb_exu_branch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_branch_ctrl_pkg.sv
// Shared definitions for the execute-stage branch controller: op encodings,
// FSM state constants and the default datapath width.
package exu_branch_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;
  localparam logic [2:0] BR_BEQ  = 3'b100;
  localparam logic [2:0] BR_BNE  = 3'b101;
  localparam logic [2:0] BR_BLT  = 3'b110;
  localparam logic [2:0] BR_BGE  = 3'b111;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_CMP = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // The reserved encoding 011 behaves exactly like an explicit "none".
  function automatic logic br_is_none(input logic [2:0] op);
    return (op == BR_NONE) || (op == 3'b011);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: decides taken and whether the
// target base is rs1 (JALR) or the PC.
module branch_cond_eval
  import exu_branch_ctrl_pkg::*;
(
  input  logic [2:0] op,
  input  logic       zero,
  input  logic       less,
  output logic       taken,
  output logic       use_rs1_base
);

  always_comb begin
    taken = 1'b0;
    case (op)
      BR_JAL, BR_JALR: taken = 1'b1;
      BR_BEQ:          taken = zero;
      BR_BNE:          taken = ~zero;
      BR_BLT:          taken = less;
      BR_BGE:          taken = ~less;
      default:         taken = 1'b0;
    endcase
  end

  assign use_rs1_base = (op == BR_JALR);

endmodule

// File: rtl/exu_branch_ctrl.sv
// Execute-stage branch controller: accepts a branch op, waits for the ALU
// compare, issues an IFU redirect when taken and pulses completion.
// Optional performance counters are built when BRANCH_STAT_EN is defined.
module exu_branch_ctrl
  import exu_branch_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_branch,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic            cmp_valid,
  input  logic            cmp_zero,
  input  logic            cmp_less,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic            done_valid,
  output logic            done_taken,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken
);

  logic [1:0]      state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic            in_idle;
  logic [2:0]      op_eval;
  logic [XLEN-1:0] pc_eval, imm_eval, rs1_eval;
  logic            cond_taken, use_rs1;
  logic [XLEN-1:0] target_sum, target;

  assign in_idle = (state_q == ST_IDLE);

  // In IDLE the op is decided from the incoming fields, which are the values
  // being latched this cycle; afterwards the latched copy is used.
  assign op_eval  = in_idle ? in_branch : op_q;
  assign pc_eval  = in_idle ? in_pc     : pc_q;
  assign imm_eval = in_idle ? in_imm    : imm_q;
  assign rs1_eval = in_idle ? in_rs1    : rs1_q;

  branch_cond_eval u_cond (
    .op           (op_eval),
    .zero         (cmp_zero),
    .less         (cmp_less),
    .taken        (cond_taken),
    .use_rs1_base (use_rs1)
  );

  assign target_sum = (use_rs1 ? rs1_eval : pc_eval) + (cond_taken ? imm_eval : XLEN'(4));
  assign target     = {target_sum[XLEN-1:1], target_sum[0] & ~use_rs1};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    taken_d    = taken_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = in_branch;
          pc_d  = in_pc;
          imm_d = in_imm;
          rs1_d = in_rs1;
          if (br_is_none(in_branch)) begin
            taken_d = 1'b0;
            state_d = ST_DONE;
          end else if (in_branch == BR_JAL) begin
            taken_d    = 1'b1;
            redir_pc_d = target;
            state_d    = ST_REDIRECT;
          end else begin
            taken_d = 1'b0;
            state_d = ST_WAIT_CMP;
          end
        end
      end
      ST_WAIT_CMP: begin
        if (cmp_valid) begin
          taken_d = cond_taken;
          if (cond_taken) begin
            redir_pc_d = target;
            state_d    = ST_REDIRECT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REDIRECT: begin
        if (redir_ready) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= BR_NONE;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      taken_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      taken_q    <= taken_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign in_ready    = in_idle;
  assign redir_valid = (state_q == ST_REDIRECT);
  assign redir_pc    = redir_pc_q;
  assign flush       = redir_valid & redir_ready;
  assign done_valid  = (state_q == ST_DONE);
  assign done_taken  = done_valid & taken_q;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_branches_q, stat_taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else if (done_valid) begin
      if (!br_is_none(op_q)) stat_branches_q <= stat_branches_q + 32'd1;
      if (taken_q)           stat_taken_q    <= stat_taken_q + 32'd1;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`else
  assign stat_branches = '0;
  assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_exu_branch_ctrl.sv
// Directed self-checking bench for exu_branch_ctrl; expected counter values
// follow BRANCH_STAT_EN.
module tb_exu_branch_ctrl;
  import exu_branch_ctrl_pkg::*;

  localparam int unsigned XLEN = 32;

`ifdef BRANCH_STAT_EN
  localparam logic [31:0] EXP_BRANCHES = 32'd5;
  localparam logic [31:0] EXP_TAKEN    = 32'd3;
  localparam logic [31:0] EXP_ONE      = 32'd1;
`else
  localparam logic [31:0] EXP_BRANCHES = 32'd0;
  localparam logic [31:0] EXP_TAKEN    = 32'd0;
  localparam logic [31:0] EXP_ONE      = 32'd0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_branch;
  logic [XLEN-1:0] in_pc, in_imm, in_rs1;
  logic            cmp_valid, cmp_zero, cmp_less;
  logic            redir_valid, redir_ready;
  logic [XLEN-1:0] redir_pc;
  logic            flush, done_valid, done_taken;
  logic [31:0]     stat_branches, stat_taken;

  int n_checks = 0;
  int n_fails  = 0;

  exu_branch_ctrl #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_branch     (in_branch),
    .in_pc         (in_pc),
    .in_imm        (in_imm),
    .in_rs1        (in_rs1),
    .cmp_valid     (cmp_valid),
    .cmp_zero      (cmp_zero),
    .cmp_less      (cmp_less),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_pc      (redir_pc),
    .flush         (flush),
    .done_valid    (done_valid),
    .done_taken    (done_taken),
    .stat_branches (stat_branches),
    .stat_taken    (stat_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one op for exactly one cycle; returns at the negedge after accept.
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1);
    in_valid  = 1'b1;
    in_branch = op;
    in_pc     = pc;
    in_imm    = imm;
    in_rs1    = rs1;
    #1;
    check("issue_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid  = 1'b0;
    in_branch = BR_NONE;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_branch   = BR_NONE;
    in_pc       = '0;
    in_imm      = '0;
    in_rs1      = '0;
    cmp_valid   = 1'b0;
    cmp_zero    = 1'b0;
    cmp_less    = 1'b0;
    redir_ready = 1'b0;
    repeat (2) tick();
    check("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_done_valid", {31'd0, done_valid}, 32'd0);
    check("rst_done_taken", {31'd0, done_taken}, 32'd0);
    check("rst_redir_pc", redir_pc, 32'd0);
    check("rst_stat_branches", stat_branches, 32'd0);
    check("rst_stat_taken", stat_taken, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // JAL with immediate redirect acceptance
    redir_ready = 1'b1;
    issue(BR_JAL, 32'h1000, 32'h20, 32'h0);
    check("jal_redir_valid", {31'd0, redir_valid}, 32'd1);
    check("jal_redir_pc", redir_pc, 32'h1020);
    check("jal_flush", {31'd0, flush}, 32'd1);
    check("jal_in_ready_busy", {31'd0, in_ready}, 32'd0);
    tick();
    check("jal_done_valid", {31'd0, done_valid}, 32'd1);
    check("jal_done_taken", {31'd0, done_taken}, 32'd1);
    check("jal_flush_single", {31'd0, flush}, 32'd0);
    tick();
    check("jal_in_ready_back", {31'd0, in_ready}, 32'd1);
    check("jal_done_over", {31'd0, done_valid}, 32'd0);

    // JALR with IFU backpressure
    redir_ready = 1'b0;
    issue(BR_JALR, 32'h5000, 32'h4, 32'h2003);
    cmp_valid = 1'b1;
    #1;
    check("jalr_wait_no_redir", {31'd0, redir_valid}, 32'd0);
    tick();
    cmp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("jalr_hold_valid", {31'd0, redir_valid}, 32'd1);
      check("jalr_hold_pc", redir_pc, 32'h2006);
      check("jalr_hold_no_flush", {31'd0, flush}, 32'd0);
      tick();
    end
    redir_ready = 1'b1;
    #1;
    check("jalr_flush", {31'd0, flush}, 32'd1);
    check("jalr_pc_at_hs", redir_pc, 32'h2006);
    tick();
    check("jalr_done_valid", {31'd0, done_valid}, 32'd1);
    check("jalr_done_taken", {31'd0, done_taken}, 32'd1);
    check("jalr_flush_single", {31'd0, flush}, 32'd0);
    check("jalr_redir_dropped", {31'd0, redir_valid}, 32'd0);
    tick();

    // BNE not taken, compare arrives late
    issue(BR_BNE, 32'h400, 32'h40, 32'h0);
    for (int i = 0; i < 2; i++) begin
      check("bne_wait_done", {31'd0, done_valid}, 32'd0);
      check("bne_wait_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    cmp_valid = 1'b1;
    cmp_zero  = 1'b1;
    tick();
    cmp_valid = 1'b0;
    cmp_zero  = 1'b0;
    check("bne_done_valid", {31'd0, done_valid}, 32'd1);
    check("bne_done_taken", {31'd0, done_taken}, 32'd0);
    check("bne_no_redir", {31'd0, redir_valid}, 32'd0);
    tick();

    // BLT taken, negative offset
    issue(BR_BLT, 32'h400, 32'hFFFF_FFF8, 32'h0);
    cmp_valid = 1'b1;
    cmp_less  = 1'b1;
    tick();
    cmp_valid = 1'b0;
    cmp_less  = 1'b0;
    check("blt_redir_valid", {31'd0, redir_valid}, 32'd1);
    check("blt_redir_pc", redir_pc, 32'h3F8);
    check("blt_flush", {31'd0, flush}, 32'd1);
    tick();
    check("blt_done_taken", {31'd0, done_taken}, 32'd1);
    tick();

    // Spurious compare in IDLE, then new op offered while busy
    cmp_valid = 1'b1;
    cmp_less  = 1'b1;
    tick();
    cmp_valid = 1'b0;
    cmp_less  = 1'b0;
    check("spur_cmp_idle", {31'd0, in_ready}, 32'd1);
    check("spur_cmp_no_redir", {31'd0, redir_valid}, 32'd0);
    check("spur_cmp_no_done", {31'd0, done_valid}, 32'd0);
    issue(BR_BEQ, 32'h800, 32'h10, 32'h0);
    in_valid  = 1'b1;
    in_branch = BR_JAL;
    in_pc     = 32'h9000;
    in_imm    = 32'h100;
    #1;
    check("busy_in_ready_0", {31'd0, in_ready}, 32'd0);
    tick();
    check("busy_in_ready_1", {31'd0, in_ready}, 32'd0);
    cmp_valid = 1'b1;
    cmp_zero  = 1'b0;
    tick();
    cmp_valid = 1'b0;
    check("beq_done_valid", {31'd0, done_valid}, 32'd1);
    check("beq_done_taken", {31'd0, done_taken}, 32'd0);
    check("beq_in_ready_done", {31'd0, in_ready}, 32'd0);
    tick();
    check("beq_in_ready_back", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b0;
    in_branch = BR_NONE;
    tick();
    check("busy_op_dropped", {31'd0, redir_valid}, 32'd0);
    check("busy_op_no_done", {31'd0, done_valid}, 32'd0);

    // none op completes directly
    issue(BR_NONE, 32'h0, 32'h0, 32'h0);
    check("none_done_valid", {31'd0, done_valid}, 32'd1);
    check("none_done_taken", {31'd0, done_taken}, 32'd0);
    check("none_no_redir", {31'd0, redir_valid}, 32'd0);
    tick();
    check("stat_branches", stat_branches, EXP_BRANCHES);
    check("stat_taken", stat_taken, EXP_TAKEN);

    // Asynchronous reset in the middle of a redirect
    redir_ready = 1'b0;
    issue(BR_JAL, 32'h1000, 32'h20, 32'h0);
    check("pre_rst_redir_valid", {31'd0, redir_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    check("async_rst_redir_pc", redir_pc, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_stat_branches", stat_branches, 32'd0);
    check("post_rst_stat_taken", stat_taken, 32'd0);
    check("post_rst_done", {31'd0, done_valid}, 32'd0);

    // BGE taken after reset
    redir_ready = 1'b1;
    issue(BR_BGE, 32'h100, 32'h80, 32'h0);
    cmp_valid = 1'b1;
    cmp_less  = 1'b0;
    tick();
    cmp_valid = 1'b0;
    check("bge_redir_pc", redir_pc, 32'h180);
    check("bge_flush", {31'd0, flush}, 32'd1);
    tick();
    check("bge_done_taken", {31'd0, done_taken}, 32'd1);
    tick();
    check("bge_stat_branches", stat_branches, EXP_ONE);
    check("bge_stat_taken", stat_taken, EXP_ONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
